multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
Moore/Mealy control sequencer that turns the single-cycle MIPS datapath into a multicycle one, sharing one memory and one ALU across instruction phases. It issues the per-state datapath control word and supports lw, sw, R-type, beq, j and addi. It waits on a memory-ready handshake for variable-latency memory and keeps a count of retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
opcode  in  6  instruction[31:26] from the instruction register; valid from DECODE onward
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU Zero (beq)
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
mem_to_reg  out  1  write-back select: 0=ALUOut, 1=MDR
reg_dst  out  1  destination select: 0=rt, 1=rd
reg_write  out  1  register file write enable
alu_src_a  out  1  0=PC, 1=register A
alu_src_b  out  2  00=register B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  2  00=add, 01=sub, 10=funct-decoded (matches the existing ALU_Control encoding)
pc_source  out  2  00=ALU result, 01=ALUOut, 10={PC+4[31:28], addr26<<2}
retire  out  1  one-cycle pulse when an instruction completes
instr_count  out  CNT_W  retired-instruction count
state_dbg  out  4  current state encoding, for the bench

Behaviour:
- Reset, sampled at the rising edge: state<=FETCH and instr_count<=0. While reset is high, all write enables (pc_write, pc_write_cond, ir_write, reg_write, mem_write), mem_read and retire are forced to 0. Reset mid-instruction abandons it with no partial writes.
- Defaults: every output not listed for a state is 0.
- FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready (Mealy).
  - mem_ready=1 moves to DECODE; otherwise stay in FETCH.
- DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target).
  - Next state by opcode: 100011 or 101011 -> MEM_ADDR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDI_EX; any other -> ILLEGAL handling.
- MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD(3): mem_read=1, i_or_d=1. mem_ready=1 -> MEM_WB; otherwise stay.
- MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0. Retire, then FETCH.
- MEM_WR(5): mem_write=1, i_or_d=1. Held until mem_ready=1, then retire and go to FETCH.
- EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10, then R_WB.
- R_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0. Retire, then FETCH.
- BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Retire, then FETCH.
- JUMP(9): pc_write=1, pc_source=10. Retire, then FETCH.
- ADDI_EX(10): alu_src_a=1, alu_src_b=10, alu_op=00, then ADDI_WB.
- ADDI_WB(11): reg_write=1, reg_dst=0, mem_to_reg=0. Retire, then FETCH.
- Latency with mem_ready tied to 1 (cycles, FETCH included): lw 5, sw 4, R 4, addi 4, beq 3, j 3. Each cycle mem_ready is low in a memory state adds one cycle.
- Retire: retire=1 in the final cycle of an instruction. instr_count increments on the same edge and wraps from all-ones to 0.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- Unused state encodings (13-15) go to FETCH on the next edge with all outputs at default.

Optional Feature:
MCFSM_ILLEGAL_TRAP_EN
- Defined:
  - Unknown opcode in DECODE -> TRAP(12). TRAP holds all enables at 0 and is left only by reset.
  - Adds output illegal_op (1 bit), high while in TRAP.
  - No retire is counted.
- Undefined: unknown opcode is treated as a NOP. DECODE -> FETCH with retire=1, and the count increments.

Decomposition:
- Package mcfsm_pkg holds:
  - the state enum (4-bit, values as numbered above);
  - the opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - the alu_src_b, alu_op and pc_source encodings.
- One sub-module, mcfsm_retire_counter, holds the CNT_W counter with synchronous reset and increment enable.
- Next-state and output decode stay in the top level.

Test Plan:
- mem_ready=1; lw, then opcode 000000 -> state_dbg 0,1,2,3,4,0,1,6,7. retire pulses in cycles 5 and 9; instr_count=2.
- sw with mem_ready low 3 cycles in MEM_WR -> mem_write high exactly 4 cycles, i_or_d=1 throughout, retire once, instr_count=1.
- FETCH with mem_ready=0 for 2 cycles -> ir_write and pc_write stay 0 for 2 cycles, then go high for 1 cycle; next state DECODE.
- beq, then j -> pc_write_cond=1 with pc_source=01 in BRANCH; pc_write=1 with pc_source=10 in JUMP; each takes 3 cycles.
- reset asserted in MEM_RD -> next state FETCH, instr_count=0, reg_write never high. Separately, CNT_W=4 with 17 R-type instructions -> instr_count=1 (wrap).
- opcode 111111 -> with the macro: TRAP, illegal_op=1, count unchanged. Without it: back to FETCH in cycle 3, count +1.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types for the multicycle MIPS control sequencer:
// state encoding, opcodes and datapath select encodings.
package mcfsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ASB_REG_B  = 2'b00;
  localparam logic [1:0] ASB_FOUR   = 2'b01;
  localparam logic [1:0] ASB_IMM    = 2'b10;
  localparam logic [1:0] ASB_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  function automatic logic is_mem_op(
    input logic [5:0] op
  );
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between sequencer (master) and datapath (slave).
// Carries opcode/mem_ready in, full per-state control word out.
interface multicycle_ctrl_fsm_if;

  logic [5:0] opcode;
  logic       mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;

  modport master (
    input  opcode,
    input  mem_ready,
    output pc_write,
    output pc_write_cond,
    output i_or_d,
    output mem_read,
    output mem_write,
    output ir_write,
    output mem_to_reg,
    output reg_dst,
    output reg_write,
    output alu_src_a,
    output alu_src_b,
    output alu_op,
    output pc_source
  );

  modport slave (
    output opcode,
    output mem_ready,
    input  pc_write,
    input  pc_write_cond,
    input  i_or_d,
    input  mem_read,
    input  mem_write,
    input  ir_write,
    input  mem_to_reg,
    input  reg_dst,
    input  reg_write,
    input  alu_src_a,
    input  alu_src_b,
    input  alu_op,
    input  pc_source
  );

endinterface

// File: rtl/multicycle_ctrl_fsm_retire_counter.sv
// Retired-instruction counter, wraps modulo 2^CNT_W.
// Ports: clk, reset (sync high), en (increment), count.
module mcfsm_retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (en)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control sequencer (lw/sw/R/beq/j/addi).
// Ports: clk, reset (sync high), bus (master control bus),
// retire, instr_count, state_dbg; illegal_op with
// MCFSM_ILLEGAL_TRAP_EN (unknown opcode traps, else NOP).
module multicycle_ctrl_fsm
  import mcfsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_ctrl_fsm_if.master  bus,
  output logic                   retire,
  output logic [CNT_W-1:0]       instr_count,
`ifdef MCFSM_ILLEGAL_TRAP_EN
  output logic                   illegal_op,
`endif
  output logic [3:0]             state_dbg
);

  state_e state;
  state_e next;

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_FETCH;
    else
      state <= next;
  end

  always_comb begin
    next              = state;
    retire            = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = ASB_REG_B;
    bus.alu_op        = ALU_ADD;
    bus.pc_source     = PCS_ALU;

    case (state)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = ASB_FOUR;
        // IR and PC+4 commit only when the fetch lands
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready)
          next = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut <= branch target for BRANCH
        bus.alu_src_b = ASB_IMM_SH;
        unique case (1'b1)
          is_mem_op(bus.opcode):
            next = S_MEM_ADDR;
          bus.opcode == OP_RTYPE:
            next = S_EXEC;
          bus.opcode == OP_BEQ:
            next = S_BRANCH;
          bus.opcode == OP_J:
            next = S_JUMP;
          bus.opcode == OP_ADDI:
            next = S_ADDI_EX;
          default: begin
`ifdef MCFSM_ILLEGAL_TRAP_EN
            next = S_TRAP;
`else
            next   = S_FETCH;
            retire = 1'b1;
`endif
          end
        endcase
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = ASB_IMM;
        next = (bus.opcode == OP_SW) ? S_MEM_WR
                                     : S_MEM_RD;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready)
          next = S_MEM_WB;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        retire         = 1'b1;
        next           = S_FETCH;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          retire = 1'b1;
          next   = S_FETCH;
        end
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_FUNCT;
        next          = S_R_WB;
      end
      S_R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        retire        = 1'b1;
        next          = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = PCS_ALUOUT;
        retire            = 1'b1;
        next              = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = PCS_JUMP;
        retire        = 1'b1;
        next          = S_FETCH;
      end
      S_ADDI_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = ASB_IMM;
        next          = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        bus.reg_write = 1'b1;
        retire        = 1'b1;
        next          = S_FETCH;
      end
      S_TRAP: begin
`ifdef MCFSM_ILLEGAL_TRAP_EN
        next = S_TRAP;
`else
        next = S_FETCH;
`endif
      end
      default: next = S_FETCH;
    endcase

    // reset abandons the instruction with no partial writes
    if (reset) begin
      retire            = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.ir_write      = 1'b0;
      bus.reg_write     = 1'b0;
      bus.mem_write     = 1'b0;
      bus.mem_read      = 1'b0;
    end
  end

  assign state_dbg = state;

`ifdef MCFSM_ILLEGAL_TRAP_EN
  assign illegal_op = (state == S_TRAP);
`endif

  mcfsm_retire_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (retire),
    .count (instr_count)
  );

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-instruction schedules
// built from latency rules, plus a CNT_W=4 copy for wrap.
module tb_multicycle_ctrl_fsm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if bif ();
  multicycle_ctrl_fsm_if sif ();
  assign sif.opcode    = bif.opcode;
  assign sif.mem_ready = bif.mem_ready;

  logic        retire, s_retire;
  logic [31:0] cnt;
  logic [3:0]  s_cnt;
  logic [3:0]  st, s_st;
`ifdef MCFSM_ILLEGAL_TRAP_EN
  logic        ill, s_ill;
`endif

  multicycle_ctrl_fsm #(.CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bif),
    .retire      (retire),
    .instr_count (cnt),
`ifdef MCFSM_ILLEGAL_TRAP_EN
    .illegal_op  (ill),
`endif
    .state_dbg   (st)
  );

  multicycle_ctrl_fsm #(.CNT_W(4)) dut4 (
    .clk         (clk),
    .reset       (reset),
    .bus         (sif),
    .retire      (s_retire),
    .instr_count (s_cnt),
`ifdef MCFSM_ILLEGAL_TRAP_EN
    .illegal_op  (s_ill),
`endif
    .state_dbg   (s_st)
  );

  int n_asrt = 0;
  int n_fail = 0;
  int unsigned m_cnt = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // expected control word per state, straight from the table
  // {pcw,pcc,iod,mrd,mwr,irw,m2r,rdst,rw,asa,asb,aop,psrc}
  function automatic logic [15:0] exp_ctrl(input int s,
                                           input bit mr);
    logic pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      0: begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1: asb = 2'b11;
      2: begin asa = 1; asb = 2'b10; end
      3: begin mrd = 1; iod = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mwr = 1; iod = 1; end
      6: begin asa = 1; aop = 2'b10; end
      7: begin rw = 1; rdst = 1; end
      8: begin asa = 1; aop = 2'b01; pcc = 1; psrc = 2'b01; end
      9: begin pcw = 1; psrc = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, asa,
            asb, aop, psrc};
  endfunction

  function automatic logic [15:0] obs_ctrl();
    return {bif.pc_write, bif.pc_write_cond, bif.i_or_d,
            bif.mem_read, bif.mem_write, bif.ir_write,
            bif.mem_to_reg, bif.reg_dst, bif.reg_write,
            bif.alu_src_a, bif.alu_src_b, bif.alu_op,
            bif.pc_source};
  endfunction

  function automatic logic [4:0] obs_en();
    return {bif.pc_write, bif.pc_write_cond, bif.ir_write,
            bif.reg_write, bif.mem_write};
  endfunction

  // Runs one instruction: fs fetch stall cycles, ms stall
  // cycles in its memory state. Returns mem_write cycles.
  task automatic run_instr(input logic [5:0] op,
                           input int fs, input int ms,
                           input string tag,
                           output int n_mw);
    int st_q[$];
    bit mr_q[$];
    bit trap = 0;
    int last;
    n_mw = 0;
    for (int i = 0; i < fs; i++) begin
      st_q.push_back(0); mr_q.push_back(0);
    end
    st_q.push_back(0); mr_q.push_back(1);
    st_q.push_back(1); mr_q.push_back(1'($urandom));
    case (op)
      6'b100011, 6'b101011: begin
        int ms_st = (op == 6'b100011) ? 3 : 5;
        st_q.push_back(2); mr_q.push_back(1'($urandom));
        for (int i = 0; i < ms; i++) begin
          st_q.push_back(ms_st); mr_q.push_back(0);
        end
        st_q.push_back(ms_st); mr_q.push_back(1);
        if (op == 6'b100011) begin
          st_q.push_back(4); mr_q.push_back(1'($urandom));
        end
      end
      6'b000000: begin
        st_q.push_back(6); mr_q.push_back(1'($urandom));
        st_q.push_back(7); mr_q.push_back(1'($urandom));
      end
      6'b000100: begin
        st_q.push_back(8); mr_q.push_back(1'($urandom));
      end
      6'b000010: begin
        st_q.push_back(9); mr_q.push_back(1'($urandom));
      end
      6'b001000: begin
        st_q.push_back(10); mr_q.push_back(1'($urandom));
        st_q.push_back(11); mr_q.push_back(1'($urandom));
      end
      default: begin
`ifdef MCFSM_ILLEGAL_TRAP_EN
        trap = 1;
        for (int i = 0; i < 3; i++) begin
          st_q.push_back(12); mr_q.push_back(1'($urandom));
        end
`endif
      end
    endcase
    last = st_q.size() - 1;
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      bif.opcode    = op;
      bif.mem_ready = mr_q[i];
      #1;
      chk({tag, " state"}, 64'(st), 64'(st_q[i]));
      chk({tag, " ctrl"}, 64'(obs_ctrl()),
          64'(exp_ctrl(st_q[i], mr_q[i])));
      chk({tag, " retire"}, 64'(retire),
          64'(i == last && !trap));
`ifdef MCFSM_ILLEGAL_TRAP_EN
      chk({tag, " illegal_op"}, 64'(ill),
          64'(st_q[i] == 12));
`endif
      if (bif.mem_write) n_mw++;
    end
    if (!trap) m_cnt++;
    @(posedge clk);
    #1;
    chk({tag, " count"}, 64'(cnt), 64'(m_cnt));
    chk({tag, " count4"}, 64'(s_cnt), 64'(m_cnt % 16));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    bif.mem_ready = 1'b1;
    #1;
    chk({tag, " en_in_reset"}, 64'(obs_en()), 64'(0));
    chk({tag, " rd_in_reset"}, 64'(bif.mem_read), 64'(0));
    chk({tag, " ret_in_reset"}, 64'(retire), 64'(0));
    @(posedge clk);
    #1;
    chk({tag, " rst_state"}, 64'(st), 64'(0));
    chk({tag, " rst_count"}, 64'(cnt), 64'(0));
    chk({tag, " rst_count4"}, 64'(s_cnt), 64'(0));
    m_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    bif.mem_ready = 1'b0;
  endtask

  initial begin : main
    logic [5:0] ops [6];
    int mw;
    ops[0] = 6'b100011; ops[1] = 6'b101011;
    ops[2] = 6'b000000; ops[3] = 6'b000100;
    ops[4] = 6'b000010; ops[5] = 6'b001000;
    reset = 1'b1;
    bif.opcode = 6'b0;
    bif.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset("init");

    run_instr(6'b100011, 0, 0, "lw", mw);
    run_instr(6'b000000, 0, 0, "rtype", mw);
    chk("lw_r total", 64'(cnt), 64'(2));

    run_instr(6'b101011, 0, 3, "sw_stall", mw);
    chk("sw mem_write cycles", 64'(mw), 64'(4));

    run_instr(6'b000000, 2, 0, "fetch_stall", mw);
    run_instr(6'b000100, 0, 0, "beq", mw);
    run_instr(6'b000010, 0, 0, "j", mw);
    run_instr(6'b001000, 1, 0, "addi", mw);
    run_instr(6'b100011, 1, 2, "lw_stall", mw);

    for (int k = 0; k < 30; k++) begin
      int idx = int'($urandom_range(0, 6));
      logic [5:0] op;
`ifdef MCFSM_ILLEGAL_TRAP_EN
      if (idx == 6) idx = 2;
`endif
      op = (idx == 6) ? 6'b001100 : ops[idx];
      run_instr(op, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), "rand", mw);
    end

    // reset while waiting in MEM_RD
    @(negedge clk);
    bif.opcode = 6'b100011; bif.mem_ready = 1'b1; #1;
    chk("mid fetch", 64'(st), 64'(0));
    @(negedge clk); #1;
    chk("mid decode", 64'(st), 64'(1));
    @(negedge clk); #1;
    chk("mid addr", 64'(st), 64'(2));
    @(negedge clk); bif.mem_ready = 1'b0; #1;
    chk("mid memrd", 64'(st), 64'(3));
    chk("mid memrd rw", 64'(bif.reg_write), 64'(0));
    do_reset("mid");
    #1;
    chk("mid after rw", 64'(bif.reg_write), 64'(0));

    for (int k = 0; k < 17; k++)
      run_instr(6'b000000, 0, 0, "r17", mw);
    chk("wrap count4", 64'(s_cnt), 64'(1));
    chk("wrap count", 64'(cnt), 64'(17));

    run_instr(6'b111111, 0, 0, "illegal", mw);
`ifdef MCFSM_ILLEGAL_TRAP_EN
    chk("illegal count held", 64'(cnt), 64'(17));
`else
    chk("illegal count nop", 64'(cnt), 64'(18));
`endif
    do_reset("final");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
